// File: rtl/task_dispatcher_if.sv
// Bundle of the request, task-manager and result signals of task_dispatcher.
//   slave  : the dispatcher side (takes i_*, drives o_*)
//   master : the environment side (drives i_*, takes o_*)
// Request group : i_req_valid/i_req_task/o_req_ready (valid/ready, FIFO input)
// Manager group : o_task_start/o_task_nbr/o_abort out, i_addr_grant/i_dest_addr/i_src_addr in
// Result group  : o_result_valid/i_result_ready/o_result_task/dst/src/status
// Status group  : o_busy, o_fifo_count
interface task_dispatcher_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          i_req_valid;
  logic [15:0]   i_req_task;
  logic          o_req_ready;
  logic          o_task_start;
  logic [15:0]   o_task_nbr;
  logic          o_abort;
  logic          i_addr_grant;
  logic [15:0]   i_dest_addr;
  logic [15:0]   i_src_addr;
  logic          o_result_valid;
  logic          i_result_ready;
  logic [15:0]   o_result_task;
  logic [15:0]   o_result_dst;
  logic [15:0]   o_result_src;
  logic [1:0]    o_result_status;
  logic          o_busy;
  logic [CW-1:0] o_fifo_count;

  modport slave (
    input  i_req_valid, i_req_task, i_addr_grant, i_dest_addr, i_src_addr, i_result_ready,
    output o_req_ready, o_task_start, o_task_nbr, o_abort, o_result_valid, o_result_task,
           o_result_dst, o_result_src, o_result_status, o_busy, o_fifo_count
  );

  modport master (
    output i_req_valid, i_req_task, i_addr_grant, i_dest_addr, i_src_addr, i_result_ready,
    input  o_req_ready, o_task_start, o_task_nbr, o_abort, o_result_valid, o_result_task,
           o_result_dst, o_result_src, o_result_status, o_busy, o_fifo_count
  );
endinterface

// File: rtl/task_dispatcher.sv
// task_dispatcher: upstream stage of the Ethernet task manager.
// Buffers task requests in a DEPTH-entry FIFO, validates the task number
// (low byte 0x10/0x20/0x30), issues one task at a time with a start pulse,
// waits up to TIMEOUT cycles for the address grant, aborts and retries up to
// MAX_RETRY times, then reports the outcome on a valid/ready result port.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous, active-high reset
//   bus    : task_dispatcher_if.slave (request, manager, result, status groups)
module task_dispatcher #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 50000000,
  parameter int unsigned MAX_RETRY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  task_dispatcher_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_INVALID = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT,
    S_REPORT
  } state_t;

  state_t        state, state_next;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          req_ready, push, pop;
  logic [15:0]   head;
  logic          head_ok;

  logic [15:0]   cur_task;
  logic [TW-1:0] timer;
  logic [2:0]    retry;
  logic          timer_expired;
  logic          retry_left;

  logic          task_start_q;
  logic [15:0]   task_nbr_q;
  logic          abort_q;
  logic [15:0]   res_dst, res_src;
  logic [1:0]    res_status;

  assign req_ready     = (count != (AW+1)'(DEPTH));
  assign push          = bus.i_req_valid && req_ready;
  assign pop           = (state == S_IDLE) && (count != '0);
  assign head          = mem[rd_ptr];
  assign head_ok       = (head[7:0] == 8'h10) || (head[7:0] == 8'h20) || (head[7:0] == 8'h30);
  assign timer_expired = (timer == TW'(TIMEOUT - 1));
  assign retry_left    = (retry < 3'(MAX_RETRY));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (count != '0) state_next = head_ok ? S_ISSUE : S_REPORT;
      S_ISSUE:  state_next = S_WAIT;
      // Grant is checked first so a grant on the last timer cycle wins.
      S_WAIT:   if (bus.i_addr_grant) state_next = S_REPORT;
                else if (timer_expired) state_next = S_ABORT;
      S_ABORT:  state_next = retry_left ? S_ISSUE : S_REPORT;
      S_REPORT: if (bus.i_result_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FIFO storage is not reset; only pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_req_task;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cur_task     <= '0;
      timer        <= '0;
      retry        <= '0;
      task_start_q <= 1'b0;
      task_nbr_q   <= '0;
      abort_q      <= 1'b0;
      res_dst      <= '0;
      res_src      <= '0;
      res_status   <= '0;
    end else begin
      state <= state_next;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Start/abort are registered from the state, so each pulse appears in
      // the cycle after ISSUE/ABORT; a retry start thus trails its abort by one.
      task_start_q <= (state == S_ISSUE);
      abort_q      <= (state == S_ABORT);
      if (state == S_ISSUE) task_nbr_q <= cur_task;

      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_task   <= head;
            retry      <= '0;
            res_dst    <= '0;
            res_src    <= '0;
            res_status <= ST_INVALID;
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (bus.i_addr_grant) begin
            res_dst    <= bus.i_dest_addr;
            res_src    <= bus.i_src_addr;
            res_status <= ST_OK;
          end
        end
        S_ABORT: begin
          if (retry_left) begin
            retry <= retry + 1'b1;
          end else begin
            res_dst    <= '0;
            res_src    <= '0;
            res_status <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready     = req_ready;
  assign bus.o_fifo_count    = count;
  assign bus.o_task_start    = task_start_q;
  assign bus.o_task_nbr      = task_nbr_q;
  assign bus.o_abort         = abort_q;
  assign bus.o_result_valid  = (state == S_REPORT);
  assign bus.o_result_task   = cur_task;
  assign bus.o_result_dst    = res_dst;
  assign bus.o_result_src    = res_src;
  assign bus.o_result_status = res_status;
  assign bus.o_busy          = (state != S_IDLE);
endmodule

// File: tb/tb_task_dispatcher.sv
module tb_task_dispatcher;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 20;

  typedef struct packed {
    logic [15:0] t;
    logic [15:0] d;
    logic [15:0] s;
    logic [1:0]  st;
  } res_t;

  logic clk;
  logic rst;

  task_dispatcher_if #(.DEPTH(DEPTH)) bus ();

  task_dispatcher #(
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT),
    .MAX_RETRY(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   results_seen = 0;
  int   extra_results = 0;
  int   accept_edge = 0;
  res_t exp_q[$];
  int   start_edges[$];
  logic [15:0] start_nbrs[$];
  int   abort_edges[$];

  logic auto_grant = 1'b0;
  logic fixed_addr = 1'b0;
  int   grant_delay = 5;
  logic [15:0] fix_dst = '0;
  logic [15:0] fix_src = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulses logged with the index of the edge that produced them;
  // every completed result transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (bus.o_task_start) begin
      start_edges.push_back(cyc);
      start_nbrs.push_back(bus.o_task_nbr);
    end
    if (bus.o_abort) abort_edges.push_back(cyc);
    if (bus.o_result_valid && bus.i_result_ready) begin
      results_seen++;
      if (exp_q.size() == 0) begin
        extra_results++;
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_task",   64'(bus.o_result_task),   64'(e.t));
        check("result_dst",    64'(bus.o_result_dst),    64'(e.d));
        check("result_src",    64'(bus.o_result_src),    64'(e.s));
        check("result_status", 64'(bus.o_result_status), 64'(e.st));
      end
    end
  end

  // Grant responder: answers each start after grant_delay cycles.
  initial begin
    logic [15:0] nbr;
    forever begin
      @(negedge clk);
      if (auto_grant && bus.o_task_start) begin
        nbr = bus.o_task_nbr;
        repeat (grant_delay) @(posedge clk);
        #1;
        bus.i_addr_grant = 1'b1;
        bus.i_dest_addr  = fixed_addr ? fix_dst : (nbr ^ 16'hA5A5);
        bus.i_src_addr   = fixed_addr ? fix_src : ~nbr;
        @(posedge clk);
        #1;
        bus.i_addr_grant = 1'b0;
        bus.i_dest_addr  = '0;
        bus.i_src_addr   = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t required completion", $time);
    $fatal(1, "simulation did not complete");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    logic acc;
    int   guard;
    guard = 0;
    do begin
      @(negedge clk);
      acc = bus.o_req_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 500);
    check(tag, 64'(acc), 64'(1));
    accept_edge = cyc;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic push_req(input logic [15:0] t);
    bus.i_req_valid = 1'b1;
    bus.i_req_task  = t;
    wait_accept("req_accept");
  endtask

  task automatic expect_res(input logic [15:0] t, input logic [15:0] d,
                            input logic [15:0] s, input logic [1:0] st);
    res_t e;
    e = '{t: t, d: d, s: s, st: st};
    exp_q.push_back(e);
  endtask

  task automatic wait_results(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (results_seen < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(results_seen >= target), 64'(1));
  endtask

  task automatic clear_logs();
    start_edges.delete();
    start_nbrs.delete();
    abort_edges.delete();
  endtask

  initial begin
    int base;
    logic [15:0] fifo_tasks [6];

    rst = 1'b1;
    bus.i_req_valid    = 1'b0;
    bus.i_req_task     = '0;
    bus.i_addr_grant   = 1'b0;
    bus.i_dest_addr    = '0;
    bus.i_src_addr     = '0;
    bus.i_result_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_req_ready",    64'(bus.o_req_ready),    64'(1));
    check("rst_fifo_count",   64'(bus.o_fifo_count),   64'(0));
    check("rst_busy",         64'(bus.o_busy),         64'(0));
    check("rst_task_start",   64'(bus.o_task_start),   64'(0));
    check("rst_task_nbr",     64'(bus.o_task_nbr),     64'(0));
    check("rst_abort",        64'(bus.o_abort),        64'(0));
    check("rst_result_valid", 64'(bus.o_result_valid), 64'(0));

    // 1: valid task, grant 5 cycles after start with fixed addresses
    clear_logs();
    auto_grant = 1'b1; fixed_addr = 1'b1; grant_delay = 5;
    fix_dst = 16'h1234; fix_src = 16'hABCD;
    base = results_seen;
    expect_res(16'h0010, 16'h1234, 16'hABCD, 2'd0);
    push_req(16'h0010);
    wait_results("t1_done", base + 1, 100);
    tick(2);
    check("t1_starts",        64'(start_edges.size()), 64'(1));
    if (start_edges.size() > 0) begin
      check("t1_start_nbr",   64'(start_nbrs[0]), 64'(16'h0010));
      check("t1_start_latency", 64'(start_edges[0] - accept_edge), 64'(2));
    end
    check("t1_aborts",        64'(abort_edges.size()), 64'(0));
    check("t1_busy_after",    64'(bus.o_busy), 64'(0));

    // 2: invalid task reports status 2 without issuing
    clear_logs();
    base = results_seen;
    expect_res(16'h0099, 16'h0000, 16'h0000, 2'd2);
    push_req(16'h0099);
    wait_results("t2_done", base + 1, 50);
    tick(2);
    check("t2_starts", 64'(start_edges.size()), 64'(0));

    // 3: no grant, one retry, then timeout status
    clear_logs();
    auto_grant = 1'b0;
    base = results_seen;
    expect_res(16'h0120, 16'h0000, 16'h0000, 2'd1);
    push_req(16'h0120);
    wait_results("t3_done", base + 1, 200);
    tick(2);
    check("t3_starts", 64'(start_edges.size()), 64'(2));
    check("t3_aborts", 64'(abort_edges.size()), 64'(2));
    if (start_edges.size() == 2 && abort_edges.size() == 2) begin
      // WAIT lasts TIMEOUT cycles; abort pulse follows the state by one edge.
      check("t3_abort1_gap", 64'(abort_edges[0] - start_edges[0]), 64'(TIMEOUT + 1));
      check("t3_restart_gap", 64'(start_edges[1] - abort_edges[0]), 64'(1));
      check("t3_abort2_gap", 64'(abort_edges[1] - start_edges[1]), 64'(TIMEOUT + 1));
      check("t3_restart_nbr", 64'(start_nbrs[1]), 64'(16'h0120));
    end

    // 4: FIFO fill with consumer stalled, then drain in order
    clear_logs();
    auto_grant = 1'b1; fixed_addr = 1'b0; grant_delay = 5;
    bus.i_result_ready = 1'b0;
    base = results_seen;
    fifo_tasks = '{16'h0110, 16'h0120, 16'h0130, 16'h0210, 16'h0220, 16'h0230};
    foreach (fifo_tasks[i]) expect_res(fifo_tasks[i], fifo_tasks[i] ^ 16'hA5A5, ~fifo_tasks[i], 2'd0);
    for (int i = 0; i < 5; i++) push_req(fifo_tasks[i]);
    check("t4_full_count", 64'(bus.o_fifo_count), 64'(4));
    check("t4_full_ready", 64'(bus.o_req_ready),  64'(0));
    bus.i_req_valid = 1'b1;
    bus.i_req_task  = fifo_tasks[5];
    tick(30);
    check("t4_held_count", 64'(bus.o_fifo_count), 64'(4));
    check("t4_held_ready", 64'(bus.o_req_ready),  64'(0));
    check("t4_held_valid", 64'(bus.o_result_valid), 64'(1));
    check("t4_held_task",  64'(bus.o_result_task), 64'(16'h0110));
    bus.i_result_ready = 1'b1;
    wait_accept("t4_last_accept");
    wait_results("t4_done", base + 6, 600);
    tick(2);
    check("t4_starts", 64'(start_edges.size()), 64'(6));

    // 5: grant on the final timer cycle wins over timeout; stray grant ignored
    clear_logs();
    grant_delay = TIMEOUT - 1;
    base = results_seen;
    expect_res(16'h0320, 16'h0320 ^ 16'hA5A5, ~16'h0320, 2'd0);
    push_req(16'h0320);
    wait_results("t5_done", base + 1, 100);
    tick(2);
    check("t5_aborts", 64'(abort_edges.size()), 64'(0));
    auto_grant = 1'b0;
    base = results_seen;
    check("t5_idle", 64'(bus.o_busy), 64'(0));
    bus.i_addr_grant = 1'b1; bus.i_dest_addr = 16'hDEAD; bus.i_src_addr = 16'hBEEF;
    tick(1);
    bus.i_addr_grant = 1'b0; bus.i_dest_addr = '0; bus.i_src_addr = '0;
    tick(10);
    check("t5_stray_results", 64'(results_seen - base), 64'(0));
    check("t5_stray_valid",   64'(bus.o_result_valid), 64'(0));
    check("t5_stray_busy",    64'(bus.o_busy), 64'(0));
    check("t5_stray_nbr",     64'(bus.o_task_nbr), 64'(16'h0320));

    // 6: reset while waiting with two requests queued
    clear_logs();
    base = results_seen;
    push_req(16'h0010);
    push_req(16'h0020);
    push_req(16'h0030);
    tick(3);
    check("t6_pre_count", 64'(bus.o_fifo_count), 64'(2));
    check("t6_pre_busy",  64'(bus.o_busy), 64'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_count",  64'(bus.o_fifo_count),   64'(0));
    check("t6_rst_ready",  64'(bus.o_req_ready),    64'(1));
    check("t6_rst_busy",   64'(bus.o_busy),         64'(0));
    check("t6_rst_nbr",    64'(bus.o_task_nbr),     64'(0));
    check("t6_rst_valid",  64'(bus.o_result_valid), 64'(0));
    check("t6_rst_task",   64'(bus.o_result_task),  64'(0));
    check("t6_rst_status", 64'(bus.o_result_status), 64'(0));
    clear_logs();
    tick(2 * TIMEOUT + 10);
    check("t6_no_start",   64'(start_edges.size()), 64'(0));
    check("t6_no_abort",   64'(abort_edges.size()), 64'(0));
    check("t6_no_result",  64'(results_seen - base), 64'(0));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    check("sb_extra", 64'(extra_results), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
